pwm_multi: RTL and testbench
============================

// Module: pwm_multi
// PURPOSE
//   Multi-channel PWM generator. One shared timebase counter drives CHANNELS compare outputs.
//   Supports edge-aligned and center-aligned modes, per-channel polarity, and glitch-free
//   shadow-register updates at the period boundary. Sits between the control/register block
//   and the output pads. Duty is given in raw counts, not scaled.
// PARAMETERS
//   WIDTH      12  counter, period and duty width in bits
//   CHANNELS   4   number of independent PWM channels
//   DEAD_WIDTH 8   dead-time counter width (used only with PWM_DEADTIME_EN)
// PORTS
//   clk_i         in   1                 clock; all logic on rising edge
//   reset_i       in   1                 synchronous, active-high reset
//   enable_ni     in   1                 active-low run enable
//   mode_i        in   1                 0 = edge-aligned, 1 = center-aligned
//   period_i      in   WIDTH             period in counts (P)
//   duty_i        in   CHANNELS*WIDTH    per-channel compare value; channel k at [k*WIDTH +: WIDTH]
//   polarity_i    in   CHANNELS          1 = invert channel output
//   update_i      in   1                 1-cycle pulse: request shadow load at next boundary
//   dead_time_i   in   DEAD_WIDTH        dead-time cycles (PWM_DEADTIME_EN only)
//   pwm_o         out  CHANNELS          PWM outputs
//   pwm_n_o       out  CHANNELS          complementary outputs (PWM_DEADTIME_EN only)
//   counter_o     out  WIDTH             timebase counter value
//   period_end_o  out  1                 1-cycle pulse on the boundary cycle
// BEHAVIOUR
// - Reset (reset_i=1 at a clock edge):
//   - Outputs: counter_o=0, direction=up, pwm_o=0, pwm_n_o=0, period_end_o=0.
//   - Internal state: all active registers = 0, update-pending flag = 0.
//   - Reset wins over every other input.
// - Active registers: period_q, mode_q, duty_q[k], polarity_q, dead_q. The compare logic uses
//   only these registers, never the inputs directly.
// - Disabled (enable_ni=1):
//   - Active registers load from the inputs every cycle; pending flag clears.
//   - counter_o=0, direction=up, period_end_o=0.
//   - pwm_o=polarity_q (inactive level); pwm_n_o=~polarity_q.
// - Idle: if period_q==0, the counter holds at 0 and outputs stay inactive as in the disabled state.
// - Edge mode:
//   - Counter runs 0..P-1, then wraps to 0.
//   - Boundary cycle: counter_o==P-1.
//   - P=1: counter stays at 0 and every cycle is a boundary.
// - Center mode:
//   - Up-count 0..P-1. At P-1, hold for one cycle and switch to down. Down-count to 0. At 0,
//     hold for one cycle and switch to up.
//   - Period is 2P cycles.
//   - Boundary cycle: counter_o==0 while direction=down.
// - Update:
//   - update_i sets the pending flag.
//   - On a boundary cycle with the flag set, or with update_i=1 in that same cycle, load
//     period/mode/duty/polarity/dead-time into the active registers and clear the flag.
//   - New values take effect from the next cycle, which is count 0 (edge) or count 0 going
//     up (center).
//   - The counter restarts at 0 when a period or mode change is loaded.
// - Compare: raw[k] = (counter_o < min(duty_q[k], period_q)).
//   - duty >= P gives 100% high; duty=0 gives 0%.
//   - Comparison is unsigned, WIDTH bits, no overflow.
// - Output: pwm_o[k] is registered as raw[k]^polarity_q[k], one cycle after counter_o.
// - period_end_o is registered and asserts in the cycle after the boundary cycle.
// - Enable de-asserting mid-period takes effect on the next edge; no period completion.
// CONFIGURATION
// - PWM_DEADTIME_EN defined:
//   - dead_time_i and pwm_n_o exist.
//   - Per channel, a dead counter restarts on every raw[k] transition.
//   - pwm_o is active only once raw[k]=1 for more than dead_q cycles.
//   - pwm_n_o is active only once raw[k]=0 for more than dead_q cycles.
//   - Polarity applies to both outputs; pwm_o and pwm_n_o are never active together.
//   - dead_q=0 gives exact complements.
//   - A pulse shorter than or equal to dead_q never asserts the output.
// - PWM_DEADTIME_EN undefined: dead_time_i, pwm_n_o and all dead-time logic are absent.
// TESTING
// - Edge, P=10, duty0=3, polarity=0 -> pwm_o[0] high 3 of every 10 cycles; period_end_o every
//   10th cycle.
// - Center, P=8, duty0=2 -> 16-cycle period; pwm_o[0] high 4 cycles, centered on the count-0
//   valley.
// - Edge, P=10, duty0=3; update_i with duty0=7 at count 4 -> current period stays 3 high;
//   next period is 7 high.
// - duty1=15 with P=10 -> pwm_o[1] constantly high; duty2=0 -> constantly low; polarity[2]=1 ->
//   constantly high.
// - Drive enable_ni=1 mid-period -> next cycle counter_o=0 and pwm_o=polarity; reset_i mid-run
//   -> all outputs 0 and idle.
// - PWM_DEADTIME_EN, P=10, duty0=5, dead=2 -> pwm_o[0] high 3 cycles and pwm_n_o[0] high 3 cycles
//   per period, never both.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM, shared edge/center timebase, shadowed updates; PWM_DEADTIME_EN adds dead-time complementary outputs
module pwm_multi #(
    parameter int WIDTH      = 12,
    parameter int CHANNELS   = 4,
    parameter int DEAD_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_ni,
    input  logic                      mode_i,
    input  logic [WIDTH-1:0]          period_i,
    input  logic [CHANNELS*WIDTH-1:0] duty_i,
    input  logic [CHANNELS-1:0]       polarity_i,
    input  logic                      update_i,
`ifdef PWM_DEADTIME_EN
    input  logic [DEAD_WIDTH-1:0]     dead_time_i,
    output logic [CHANNELS-1:0]       pwm_n_o,
`endif
    output logic [CHANNELS-1:0]       pwm_o,
    output logic [WIDTH-1:0]          counter_o,
    output logic                      period_end_o
);
    typedef logic [CHANNELS-1:0][WIDTH-1:0] duty_t;
    logic [WIDTH-1:0]    cnt_q, cnt_d, period_q, period_d;
    logic                dir_q, dir_d, mode_q, mode_d, pend_q, pend_d, pe_q, pe_d;
    duty_t               duty_q, duty_d;
    logic [CHANNELS-1:0] pol_q, pol_d, pwm_q, pwm_d, raw;
    logic                run, at_top, bnd, load, take;

    // Timebase, boundary detection and shadow-register loading
    always_comb begin
        run      = !enable_ni && period_q != '0;
        at_top   = cnt_q == period_q - 1'b1;
        bnd      = mode_q ? (dir_q && cnt_q == '0) : at_top;
        load     = run && bnd && (pend_q || update_i);
        take     = enable_ni || load;
        period_d = take ? period_i : period_q;
        mode_d   = take ? mode_i : mode_q;
        duty_d   = take ? duty_i : duty_q;
        pol_d    = take ? polarity_i : pol_q;
        pend_d   = !take && (pend_q || update_i);
        pe_d     = run && bnd;
        cnt_d    = '0;
        dir_d    = 1'b0;
        if (run && !load) begin
            if (!mode_q) cnt_d = at_top ? '0 : cnt_q + 1'b1;
            else if (!dir_q) begin
                cnt_d = at_top ? cnt_q : cnt_q + 1'b1;
                dir_d = at_top;
            end else begin
                cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                dir_d = cnt_q != '0;
            end
        end
    end

    // Raw compare against min(duty, period) using only the active registers
    always_comb begin
        raw = '0;
        for (int k = 0; k < CHANNELS; k++) raw[k] = cnt_q < duty_q[k] && cnt_q < period_q;
    end

    // Active registers, timebase and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            period_q <= '0;
            mode_q   <= 1'b0;
            duty_q   <= '0;
            pol_q    <= '0;
            pend_q   <= 1'b0;
            pe_q     <= 1'b0;
            pwm_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            duty_q   <= duty_d;
            pol_q    <= pol_d;
            pend_q   <= pend_d;
            pe_q     <= pe_d;
            pwm_q    <= pwm_d;
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [CHANNELS-1:0][DEAD_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [CHANNELS-1:0]                 prev_q, prev_d, pwm_n_q, pwm_n_d, on;
    logic [DEAD_WIDTH-1:0]               dead_q, dead_d;

    // Per-channel run length of the current raw level gates both outputs
    always_comb begin
        dead_d = take ? dead_time_i : dead_q;
        prev_d = enable_ni ? '0 : raw;
        on     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            dcnt_d[k] = (enable_ni || raw[k] != prev_q[k]) ? '0 :
                        (&dcnt_q[k] ? dcnt_q[k] : dcnt_q[k] + 1'b1);
            on[k]     = dcnt_d[k] >= dead_q;
        end
        pwm_d   = run ? ((raw & on) ^ pol_q) : pol_d;
        pwm_n_d = run ? ((~raw & on) ^ pol_q) : ~pol_d;
    end

    // Dead-time state and complementary output register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dcnt_q  <= '0;
            prev_q  <= '0;
            pwm_n_q <= '0;
            dead_q  <= '0;
        end else begin
            dcnt_q  <= dcnt_d;
            prev_q  <= prev_d;
            pwm_n_q <= pwm_n_d;
            dead_q  <= dead_d;
        end
    end

    assign pwm_n_o = pwm_n_q;
`else
    // Output level: compare result with polarity while running, inactive level otherwise
    always_comb pwm_d = run ? (raw ^ pol_q) : pol_d;

    if (DEAD_WIDTH < 1) begin : g_bad_dead_width
    end
`endif

    assign pwm_o        = pwm_q;
    assign counter_o    = cnt_q;
    assign period_end_o = pe_q;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed table plus hand-written sequences for pwm_multi
module tb_pwm_multi;
    localparam int W = 12, C = 4;
    logic           clk = 1'b0, reset_i, enable_ni, mode_i, update_i, period_end_o;
    logic [W-1:0]   period_i, counter_o;
    logic [C*W-1:0] duty_i;
    logic [C-1:0]   polarity_i, pwm_o;
`ifdef PWM_DEADTIME_EN
    logic [7:0]     dead_time_i = 8'd0;
    logic [C-1:0]   pwm_n_o;
`endif
    int n_chk = 0, n_pass = 0;

    typedef struct {
        logic            mode;
        logic [11:0]     period;
        logic [47:0]     duty;
        logic [3:0]      pol;
        int              win;
        logic [3:0][7:0] hi;
        int              pe;
    } vec_t;
    vec_t v[7];

    always #5 clk = ~clk;

    pwm_multi dut (
        .clk_i(clk), .reset_i(reset_i), .enable_ni(enable_ni), .mode_i(mode_i),
        .period_i(period_i), .duty_i(duty_i), .polarity_i(polarity_i), .update_i(update_i),
`ifdef PWM_DEADTIME_EN
        .dead_time_i(dead_time_i), .pwm_n_o(pwm_n_o),
`endif
        .pwm_o(pwm_o), .counter_o(counter_o), .period_end_o(period_end_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic load_cfg(input logic m, input int p, input logic [47:0] d, input logic [3:0] pol);
        enable_ni = 1'b1; update_i = 1'b0; mode_i = m;
        period_i = W'(p); duty_i = d; polarity_i = pol;
        repeat (2) @(negedge clk);
        enable_ni = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t t);
        int cnt_hi[4] = '{0, 0, 0, 0};
        int pe = 0;
        load_cfg(t.mode, int'(t.period), t.duty, t.pol);
        repeat (t.win) begin
            @(negedge clk);
            for (int k = 0; k < C; k++) cnt_hi[k] += int'(pwm_o[k]);
            pe += int'(period_end_o);
        end
        for (int k = 0; k < C; k++) chk($sformatf("v%0d_high_ch%0d", n, k), cnt_hi[k], int'(t.hi[k]));
        chk($sformatf("v%0d_period_end", n), pe, t.pe);
        chk($sformatf("v%0d_counter_end", n), int'(counter_o), 0);
    endtask

    initial begin
        int ph[4];
        int pes;
        v[0] = '{1'b0, 12'd10, {12'd0, 12'd0, 12'd15, 12'd3}, 4'b0100, 20, {8'd0, 8'd20, 8'd20, 8'd6}, 2};
        v[1] = '{1'b1, 12'd8,  {12'd0, 12'd4, 12'd8, 12'd2},  4'b0000, 32, {8'd0, 8'd16, 8'd32, 8'd8}, 2};
        v[2] = '{1'b0, 12'd1,  {12'd0, 12'd0, 12'd0, 12'd1},  4'b1000, 5,  {8'd5, 8'd0, 8'd0, 8'd5},   5};
        v[3] = '{1'b0, 12'd4,  {12'd3, 12'd1, 12'd4, 12'd2},  4'b1111, 8,  {8'd2, 8'd6, 8'd0, 8'd4},   2};
        v[4] = '{1'b1, 12'd1,  {12'd0, 12'd0, 12'd0, 12'd1},  4'b0000, 4,  {8'd0, 8'd0, 8'd0, 8'd4},   2};
        v[5] = '{1'b1, 12'd3,  {12'd0, 12'd3, 12'd2, 12'd1},  4'b0000, 12, {8'd0, 8'd12, 8'd8, 8'd4},  2};
        v[6] = '{1'b0, 12'd0,  {12'd0, 12'd0, 12'd0, 12'd5},  4'b0011, 6,  {8'd0, 8'd0, 8'd6, 8'd6},   0};

        reset_i = 1'b1; enable_ni = 1'b1; mode_i = 1'b0; update_i = 1'b0;
        period_i = 12'd10; duty_i = '0; polarity_i = 4'b1111;
        repeat (2) @(negedge clk);
        chk("reset_counter", int'(counter_o), 0);
        chk("reset_pwm", int'(pwm_o), 0);
        chk("reset_period_end", int'(period_end_o), 0);
        reset_i = 1'b0;

        for (int n = 0; n < 7; n++) run_vec(n, v[n]);

        ph = '{0, 0, 0, 0};
        pes = 0;
        load_cfg(1'b0, 10, {12'd0, 12'd0, 12'd0, 12'd3}, 4'b0000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ph[i / 10] += int'(pwm_o[0]);
            pes += int'(period_end_o);
            if (i == 3) chk("upd_counter_at_request", int'(counter_o), 4);
            if (i == 9) chk("upd_period_end_at_9", int'(period_end_o), 1);
            update_i = (i == 3 || i == 28);
            if (i == 3) duty_i[11:0] = 12'd7;
            if (i == 28) duty_i[11:0] = 12'd1;
        end
        chk("upd_p0_high", ph[0], 3);
        chk("upd_p1_high", ph[1], 7);
        chk("upd_p2_high", ph[2], 7);
        chk("upd_p3_boundary_high", ph[3], 1);
        chk("upd_period_ends", pes, 4);

        repeat (3) @(negedge clk);
        enable_ni = 1'b1;
        polarity_i = 4'b0101;
        @(negedge clk);
        chk("dis_counter", int'(counter_o), 0);
        chk("dis_pwm", int'(pwm_o), 5);
        chk("dis_period_end", int'(period_end_o), 0);

        load_cfg(1'b0, 10, {12'd0, 12'd0, 12'd0, 12'd3}, 4'b0000);
        repeat (9) @(negedge clk);
        chk("rst_pre_counter", int'(counter_o), 9);
        reset_i = 1'b1;
        update_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_counter", int'(counter_o), 0);
        chk("rst_mid_pwm", int'(pwm_o), 0);
        chk("rst_mid_period_end", int'(period_end_o), 0);
        reset_i = 1'b0;
        update_i = 1'b0;
        polarity_i = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_idle_counter", int'(counter_o), 0);
        chk("rst_idle_pwm", int'(pwm_o), 0);

`ifdef PWM_DEADTIME_EN
        begin
            int hp = 0, hn = 0, both = 0;
            dead_time_i = 8'd2;
            load_cfg(1'b0, 10, {12'd0, 12'd0, 12'd0, 12'd5}, 4'b0000);
            repeat (20) begin
                @(negedge clk);
                hp += int'(pwm_o[0]);
                hn += int'(pwm_n_o[0]);
                both += int'(pwm_o[0] & pwm_n_o[0]);
            end
            chk("dt_pwm_high", hp, 6);
            chk("dt_pwm_n_high", hn, 6);
            chk("dt_overlap", both, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
